axis_beat_gen: RTL and testbench
================================

# axis_beat_gen

Upstream traffic source for the stream throughput-measurement chain. It emits a programmed number of 128-bit AXI-Stream beats with a deterministic, self-checking payload, and drives the slave side of the downstream beat/cycle counter stage. One run is launched per `start` pulse. Run status and a sent-beat count are exposed for the host/test harness.

## Interface
Parameters:
- `DATA_W`, 128: stream data width; fixed at 128, payload format below assumes it.
- `CNT_W`, 32: width of `beat_num`, `seed` and `sent_cnt`.
- `GAP_W`, 8: width of `gap_cycles` (used only with the gap feature compiled in).

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle launch pulse; honoured only in IDLE.
- `beat_num`  in  CNT_W: number of beats per run; latched at accepted `start`.
- `seed`  in  CNT_W: payload seed; latched at accepted `start`.
- `gap_cycles`  in  GAP_W: idle cycles inserted after each accepted beat; latched at accepted `start`.
- `m_axis_tvalid`  out  1: beat valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tdata`  out  DATA_W: beat payload.
- `m_axis_tlast`  out  1: high on the final beat of a run.
- `busy`  out  1: high in RUN and GAP.
- `done`  out  1: one-cycle pulse at end of run.
- `sent_cnt`  out  CNT_W: beats accepted in current/last run.

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE: `start`=1 latches `beat_num`/`seed`/`gap_cycles`, clears `sent_cnt` and beat index `idx`; next state RUN if latched `beat_num`>0, else DONE (no beats sent).
- RUN: `m_axis_tvalid`=1. On `tvalid && tready`: `idx`+1, `sent_cnt`+1. If that beat was the last (`idx`==`beat_num`-1) -> DONE; else if gap enabled and latched gap>0 -> GAP; else stay RUN.
- GAP: `tvalid`=0; counts latched gap cycles, then -> RUN.
- DONE: `done`=1 for exactly one cycle, -> IDLE.
- Payload of beat `idx`: [31:0]=`idx`, [63:32]=~`idx`, [95:64]=latched `seed`, [127:96]=`seed`+`idx` (mod 2^32).
- `m_axis_tlast` = `tvalid` && (`idx`==`beat_num`-1).
- AXIS rules: once `tvalid` rises it stays high and `tdata`/`tlast` stay stable until accepted; `tvalid` never depends combinationally on `tready`.
- `start` while not IDLE is ignored (no restart, no relatch).
- `sent_cnt` holds after DONE until next accepted `start`.
- All arithmetic wraps at CNT_W bits; `beat_num`=2^32-1 is legal.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `busy`=0, `done`=0, `sent_cnt`=0, state IDLE.
- Reset mid-run: all outputs take reset values at the clock edge where `reset` is sampled high; in-flight beat is abandoned.
- `start` at edge N -> `tvalid`=1 from cycle N+1.
- Full throughput with `tready`=1 and no gap: one beat per cycle, `beat_num` consecutive cycles.
- With gap G: accepted beat at cycle K -> next `tvalid` at cycle K+1+G.
- Last beat accepted at cycle K -> `done`=1 in cycle K+1, `busy`=0 in K+1, IDLE at K+2; new `start` accepted from K+2.
- `beat_num`=0: `start` at N -> `done` at N+1, no `tvalid`.

## Configuration
- `AXIS_BEAT_GEN_GAP_EN`: defined -> GAP state and `gap_cycles` latching/timer present as above. Undefined -> GAP state removed, `gap_cycles` ignored, RUN always issues back-to-back beats.

## Structure
- Package `axis_beat_gen_pkg`: FSM state typedef, payload field offsets/widths, DATA_W/CNT_W defaults.
- One sub-module `axis_gap_timer` (load, count-down, expire pulse), instantiated only under `AXIS_BEAT_GEN_GAP_EN`.

## Test plan
- `beat_num`=4, `seed`=0x10, `tready`=1 -> 4 consecutive valid cycles, tdata[31:0]=0..3, [127:96]=0x10..0x13, `tlast` on beat 3, `done` next cycle, `sent_cnt`=4.
- Same run, `tready` toggling 1,0,0,1,... -> `tvalid`/`tdata` held stable while `tready`=0, 4 beats total, no duplicates.
- `beat_num`=0 -> `done` one cycle after `start`, `tvalid` never asserted, `sent_cnt`=0.
- Gap enabled, `gap_cycles`=3, `beat_num`=3, `tready`=1 -> `tvalid` at cycles 1, 5, 9 after start; disabled build -> cycles 1, 2, 3.
- `start` pulsed again mid-run -> ignored, run completes with original `beat_num`.
- `reset` asserted on beat 2 of 8 -> all outputs zero next edge; fresh `start` runs 8 beats from `idx`=0.

Source files
------------

// File: rtl/axis_beat_gen_pkg.sv
// rtl/axis_beat_gen_pkg.sv - shared types, payload layout and defaults for axis_beat_gen
// AXIS_BEAT_GEN_GAP_EN adds the GAP state to the FSM encoding.
package axis_beat_gen_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 32;
  localparam int GAP_W_DEF  = 8;

  localparam int FIELD_W  = 32;
  localparam int IDX_LSB  = 0;
  localparam int NIDX_LSB = 32;
  localparam int SEED_LSB = 64;
  localparam int SUM_LSB  = 96;

`ifdef AXIS_BEAT_GEN_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd3
  } state_e;
`endif

  // Self-checking beat: index, its complement, the seed and seed+index.
  function automatic logic [DATA_W_DEF-1:0] make_payload(input logic [FIELD_W-1:0] idx,
                                                         input logic [FIELD_W-1:0] seed);
    logic [DATA_W_DEF-1:0] p;
    p = '0;
    p[IDX_LSB  +: FIELD_W] = idx;
    p[NIDX_LSB +: FIELD_W] = ~idx;
    p[SEED_LSB +: FIELD_W] = seed;
    p[SUM_LSB  +: FIELD_W] = seed + idx;
    return p;
  endfunction

endpackage

// File: rtl/axis_gap_timer.sv
// rtl/axis_gap_timer.sv - loadable down-counter that pulses expire on its last counted cycle
module axis_gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == ONE);

endmodule

// File: rtl/axis_beat_gen.sv
// rtl/axis_beat_gen.sv - AXI-Stream beat source emitting a programmed run of self-checking beats
// Optional inter-beat gap logic is compiled in with AXIS_BEAT_GEN_GAP_EN.
module axis_beat_gen
  import axis_beat_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  beat_num,
  input  logic [CNT_W-1:0]  seed,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   beat_num_q, beat_num_d;
  logic [CNT_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
  logic               tvalid_q, tvalid_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   idx_next;
  logic [CNT_W-1:0]   last_idx;

`ifdef AXIS_BEAT_GEN_GAP_EN
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               gap_load;
  logic               gap_expire;

  axis_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_q),
    .expire   (gap_expire)
  );
`else
  logic               unused_gap;
  assign unused_gap = ^gap_cycles;
`endif

  assign idx_next = idx_q + ONE;
  assign last_idx = beat_num_q - ONE;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_num_d = beat_num_q;
    seed_d     = seed_q;
    sent_cnt_d = sent_cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef AXIS_BEAT_GEN_GAP_EN
    gap_d      = gap_q;
    gap_load   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          beat_num_d = beat_num;
          seed_d     = seed;
          idx_d      = '0;
          sent_cnt_d = '0;
`ifdef AXIS_BEAT_GEN_GAP_EN
          gap_d      = gap_cycles;
`endif
          if (beat_num != '0) begin
            state_d  = ST_RUN;
            tvalid_d = 1'b1;
            tdata_d  = make_payload(FIELD_W'(0), seed[FIELD_W-1:0]);
            tlast_d  = (beat_num == ONE);
            busy_d   = 1'b1;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (m_axis_tready) begin
          idx_d      = idx_next;
          sent_cnt_d = sent_cnt_q + ONE;
          // tlast_q already encodes idx == beat_num-1 for the beat on the bus.
          if (tlast_q) begin
            state_d  = ST_DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`ifdef AXIS_BEAT_GEN_GAP_EN
          end else if (gap_q != '0) begin
            state_d  = ST_GAP;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            gap_load = 1'b1;
`endif
          end else begin
            tdata_d  = make_payload(idx_next[FIELD_W-1:0], seed_q[FIELD_W-1:0]);
            tlast_d  = (idx_next == last_idx);
          end
        end
      end
`ifdef AXIS_BEAT_GEN_GAP_EN
      ST_GAP: begin
        if (gap_expire) begin
          state_d  = ST_RUN;
          tvalid_d = 1'b1;
          tdata_d  = make_payload(idx_q[FIELD_W-1:0], seed_q[FIELD_W-1:0]);
          tlast_d  = (idx_q == last_idx);
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      beat_num_q <= '0;
      seed_q     <= '0;
      sent_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef AXIS_BEAT_GEN_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_num_q <= beat_num_d;
      seed_q     <= seed_d;
      sent_cnt_q <= sent_cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef AXIS_BEAT_GEN_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sent_cnt      = sent_cnt_q;

endmodule

// File: tb/tb_axis_beat_gen.sv
// tb/tb_axis_beat_gen.sv - self-checking bench for axis_beat_gen (table runs, reset corner, random runs)
module tb_axis_beat_gen;

  localparam int BUDGET = 400;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  beat_num;
  logic [31:0]  seed;
  logic [7:0]   gap_cycles;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic         busy;
  logic         done;
  logic [31:0]  sent_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_beat_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .beat_num      (beat_num),
    .seed          (seed),
    .gap_cycles    (gap_cycles),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .sent_cnt      (sent_cnt)
  );

  typedef struct {
    logic [31:0] bn;
    logic [31:0] sd;
    logic [7:0]  gp;
    int          mode;
    int          poke;
    int          exp_done;
    logic [31:0] exp_sent;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_payload(input int i, input logic [31:0] s);
    logic [31:0] ix;
    ix = 32'(i);
    return {s + ix, s, ~ix, ix};
  endfunction

  // Reference: beat i must appear exactly when the previous acceptance plus the gap has elapsed.
  task automatic run_one(input logic [31:0] bn, input logic [31:0] sd, input logic [7:0] gp,
                         input int mode, input int poke,
                         output int done_at, output logic [31:0] sent_after);
    int   geff;
    int   exp_idx;
    int   next_valid;
    int   done_c;
    logic exp_valid;
`ifdef AXIS_BEAT_GEN_GAP_EN
    geff = int'(gp);
`else
    geff = 0;
`endif
    beat_num   = bn;
    seed       = sd;
    gap_cycles = gp;
    start      = 1'b1;
    m_axis_tready = 1'b0;
    step();
    start      = 1'b0;
    exp_idx    = 0;
    next_valid = 1;
    done_c     = (bn == 32'd0) ? 1 : -1;
    done_at    = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
      start = (c == poke);
      if (c == poke) begin
        beat_num = bn + 32'd5;
        seed     = ~sd;
      end
      exp_valid = (32'(exp_idx) < bn) && (c >= next_valid);
      check("tvalid", {127'd0, m_axis_tvalid}, {127'd0, exp_valid});
      if (exp_valid && m_axis_tvalid) begin
        check("tdata", m_axis_tdata, exp_payload(exp_idx, sd));
        check("tlast", {127'd0, m_axis_tlast}, {127'd0, (32'(exp_idx) == bn - 32'd1)});
      end
      check("busy", {127'd0, busy}, {127'd0, (32'(exp_idx) < bn)});
      check("done", {127'd0, done}, {127'd0, (c == done_c)});
      check("sent_cnt", {96'd0, sent_cnt}, {96'd0, 32'(exp_idx)});
      if (c == done_c) begin
        done_at = c;
        break;
      end
      if (exp_valid && m_axis_tready) begin
        exp_idx++;
        next_valid = c + 1 + geff;
        if (32'(exp_idx) == bn) done_c = c + 1;
      end
      step();
    end
    if (done_at < 0) begin
      failures++;
      checks++;
      $display("FAIL run_timeout: actual=no done required=done within %0d cycles", BUDGET);
    end
    start = 1'b0;
    m_axis_tready = 1'b0;
    step();
    sent_after = sent_cnt;
    check("idle_done", {127'd0, done}, 128'd0);
    check("idle_busy", {127'd0, busy}, 128'd0);
  endtask

  vec_t        vecs[7];
  int          d_at;
  logic [31:0] s_after;

  initial begin
    vecs[0] = '{bn: 32'd4, sd: 32'h10,       gp: 8'd0, mode: 0, poke: 0, exp_done: 5, exp_sent: 32'd4};
    vecs[1] = '{bn: 32'd4, sd: 32'h10,       gp: 8'd0, mode: 1, poke: 0, exp_done: 9, exp_sent: 32'd4};
    vecs[2] = '{bn: 32'd0, sd: 32'h55,       gp: 8'd0, mode: 0, poke: 0, exp_done: 1, exp_sent: 32'd0};
`ifdef AXIS_BEAT_GEN_GAP_EN
    vecs[3] = '{bn: 32'd3, sd: 32'h20,       gp: 8'd3, mode: 0, poke: 0, exp_done: 10, exp_sent: 32'd3};
`else
    vecs[3] = '{bn: 32'd3, sd: 32'h20,       gp: 8'd3, mode: 0, poke: 0, exp_done: 4, exp_sent: 32'd3};
`endif
    vecs[4] = '{bn: 32'd3, sd: 32'hFFFFFFFE, gp: 8'd0, mode: 0, poke: 2, exp_done: 4, exp_sent: 32'd3};
    vecs[5] = '{bn: 32'd2, sd: 32'h7,        gp: 8'd1, mode: 1, poke: 0, exp_done: 5, exp_sent: 32'd2};
    vecs[6] = '{bn: 32'd1, sd: 32'hABCD,     gp: 8'd2, mode: 0, poke: 0, exp_done: 2, exp_sent: 32'd1};

    reset = 1'b1;
    start = 1'b0;
    beat_num = '0;
    seed = '0;
    gap_cycles = '0;
    m_axis_tready = 1'b0;
    step();
    step();
    check("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_tlast", {127'd0, m_axis_tlast}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_sent", {96'd0, sent_cnt}, 128'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      run_one(vecs[v].bn, vecs[v].sd, vecs[v].gp, vecs[v].mode, vecs[v].poke, d_at, s_after);
      check($sformatf("vec%0d_done_cycle", v), 128'(d_at), 128'(vecs[v].exp_done));
      check($sformatf("vec%0d_sent_hold", v), {96'd0, s_after}, {96'd0, vecs[v].exp_sent});
    end

    // Reset while beat 2 of 8 is on the bus, then a fresh run from index 0.
    beat_num = 32'd8;
    seed = 32'h100;
    gap_cycles = 8'd0;
    start = 1'b1;
    m_axis_tready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_tdata", m_axis_tdata, exp_payload(2, 32'h100));
    reset = 1'b1;
    step();
    check("midrst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    check("midrst_tdata", m_axis_tdata, 128'd0);
    check("midrst_tlast", {127'd0, m_axis_tlast}, 128'd0);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_done", {127'd0, done}, 128'd0);
    check("midrst_sent", {96'd0, sent_cnt}, 128'd0);
    reset = 1'b0;
    m_axis_tready = 1'b0;
    step();
    run_one(32'd8, 32'h200, 8'd0, 0, 0, d_at, s_after);
    check("post_rst_done_cycle", 128'(d_at), 128'd9);
    check("post_rst_sent", {96'd0, s_after}, 128'd8);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] rbn;
      logic [31:0] rsd;
      logic [7:0]  rgp;
      int          rpk;
      rbn = 32'($urandom_range(0, 10));
      rsd = $urandom;
      rgp = 8'($urandom_range(0, 3));
      rpk = $urandom_range(0, 6);
      run_one(rbn, rsd, rgp, 2, rpk, d_at, s_after);
      check($sformatf("rand%0d_sent", r), {96'd0, s_after}, {96'd0, rbn});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
